// File: rtl/sensor_scan_arbiter.sv
// Synchronises and debounces N_CH sensor request lines, then grants one actuator at a time
// with a guaranteed minimum on-time, in fixed-priority or round-robin order.
module sensor_scan_arbiter #(
  parameter  int N_CH     = 6,
  parameter  int DEBOUNCE = 4,
  parameter  int MIN_HOLD = 8,
  localparam int IDX_W    = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  sensor,
  input  logic             rr_mode,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  actuator,
  output logic [IDX_W-1:0] display,
  output logic             active
);

  // state | meaning
  // IDLE  | nothing granted, waiting for any pending bit
  // SERVE | one channel granted, hold counting down to the next arbitration
  typedef enum logic {IDLE, SERVE} state_t;

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE - 1);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(MIN_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  ONE      = N_CH'(1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W+1)'(N_CH);

  logic [N_CH-1:0]  sync1, sync2;
  logic [CW-1:0]    cnt [N_CH];
  state_t           state, state_n;
  logic [IDX_W-1:0] grant, grant_n;
  logic [HW-1:0]    hold, hold_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;

  logic [IDX_W:0]    shift_amt, rr_sum;
  logic [2*N_CH-1:0] rot_full;
  logic [IDX_W-1:0]  fix_win, rr_off, win;

  function automatic logic [IDX_W-1:0] first_set(input logic [N_CH-1:0] v);
    first_set = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (v[i]) first_set = IDX_W'(i);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      pending <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      for (int i = 0; i < N_CH; i++) begin
        if (sync2[i] != pending[i]) begin
          if (cnt[i] == CNT_MAX) begin
            pending[i] <= ~pending[i];
            cnt[i]     <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Round-robin: rotate pending so bit 0 is channel rr_ptr+1, then undo the rotation.
  always_comb begin
    fix_win   = first_set(pending);
    shift_amt = {1'b0, rr_ptr} + (IDX_W+1)'(1);
    rot_full  = {pending, pending} >> shift_amt;
    rr_off    = first_set(rot_full[N_CH-1:0]);
    rr_sum    = shift_amt + {1'b0, rr_off};
    if (rr_sum >= N_WIDE) rr_sum = rr_sum - N_WIDE;
    win = rr_mode ? rr_sum[IDX_W-1:0] : fix_win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      hold   <= '0;
      rr_ptr <= LAST_CH;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      hold   <= hold_n;
      rr_ptr <= rr_ptr_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    hold_n   = hold;
    rr_ptr_n = rr_ptr;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_n  = SERVE;
          grant_n  = win;
          hold_n   = HOLD_MAX;
          rr_ptr_n = win;
        end
      end
      SERVE: begin
        if (hold != '0) begin
          hold_n = hold - 1'b1;
        end else if (!(|pending)) begin
          state_n = IDLE;
          grant_n = '0;
        end else begin
          grant_n  = win;
          hold_n   = HOLD_MAX;
          rr_ptr_n = win;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign active   = (state == SERVE);
  assign display  = grant;
  assign actuator = active ? (ONE << grant) : '0;

endmodule

// File: tb/tb_sensor_scan_arbiter.sv
// Bench for sensor_scan_arbiter: directed scenarios plus random sensor traffic,
// every cycle compared against a behavioural model of debounce and arbitration.
module tb_sensor_scan_arbiter;
  localparam int N    = 6;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int IW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  sensor;
  logic          rr_mode;
  logic [N-1:0]  pending, actuator;
  logic [IW-1:0] display;
  logic          active;

  int n_checks = 0;
  int n_errors = 0;

  sensor_scan_arbiter #(.N_CH(N), .DEBOUNCE(DEB), .MIN_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .rr_mode(rr_mode),
    .pending(pending), .actuator(actuator), .display(display), .active(active)
  );

  always #5 clk = ~clk;

  // model: sampled sensor pipeline, accepted levels, disagreement run lengths,
  // current grant (-1 = idle), cycles it has been shown so far, last granted channel
  logic [N-1:0] m_s1, m_s2, m_pend;
  int m_run [N];
  int m_gnt, m_served, m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] p, input logic rr, input int ptr);
    if (!rr) begin
      for (int i = 0; i < N; i++) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_pend = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_gnt = -1; m_served = 0; m_ptr = N - 1;
  endtask

  task automatic model_edge();
    logic [N-1:0] old_pend;
    int w;
    old_pend = m_pend;
    if (m_gnt >= 0 && m_served < HOLD) begin
      m_served++;
    end else if (old_pend != '0) begin
      w = pick(old_pend, rr_mode, m_ptr);
      m_gnt = w; m_served = 1; m_ptr = w;
    end else begin
      m_gnt = -1; m_served = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != old_pend[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_pend[i] = ~m_pend[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = sensor;
  endtask

  task automatic compare();
    logic [N-1:0] exp_act;
    int idx;
    exp_act = '0;
    if (m_gnt >= 0) exp_act[m_gnt] = 1'b1;
    chk("pending", 32'(pending), 32'(m_pend));
    chk("actuator", 32'(actuator), 32'(exp_act));
    chk("display", 32'(display), (m_gnt < 0) ? 0 : m_gnt);
    chk("active", 32'(active), (m_gnt >= 0) ? 1 : 0);
    chk("onehot0", 32'($onehot0(actuator)), 1);
    chk("active_vs_act", 32'(active), 32'(|actuator));
    if (active) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (actuator[i]) idx = i;
      chk("display_idx", 32'(display), idx);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    compare();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_for_act(input logic [N-1:0] pat, input string tag);
    int n = 0;
    while (actuator !== pat && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(actuator), 32'(pat));
  endtask

  task automatic measure_hold(input logic [N-1:0] pat, output int held);
    int k = 0;
    held = 1;
    do begin
      tick();
      if (actuator == pat) held++;
      k++;
    end while (actuator == pat && k < 30);
  endtask

  initial begin
    int n, held, flip_div;
    logic [N-1:0] seen, e;

    reset = 1'b1; sensor = '0; rr_mode = 1'b0;
    model_reset();
    tick();
    tick();

    // held sensor: debounce latency, then grant one cycle later
    reset = 1'b0; sensor = 6'b000100;
    n = 0;
    while (!pending[2] && n < 20) begin tick(); n++; end
    chk("t1_pend_latency", n, 6);
    tick();
    chk("t1_actuator", 32'(actuator), 32'(6'b000100));
    chk("t1_display", 32'(display), 2);

    // 3-cycle glitch is filtered
    sensor = '0;
    apply_reset();
    sensor = 6'b000010;
    seen = '0;
    repeat (3) begin tick(); seen |= pending | actuator; end
    sensor = '0;
    repeat (12) begin tick(); seen |= pending | actuator; end
    chk("t2_glitch", 32'(seen), 0);

    // no preemption of ch4 by ch0 arriving during the hold
    apply_reset();
    rr_mode = 1'b0; sensor = 6'b010000;
    repeat (3) tick();
    sensor = 6'b010001;
    wait_for_act(6'b010000, "t3_grant4");
    measure_hold(6'b010000, held);
    chk("t3_hold", held, HOLD);
    chk("t3_next", 32'(actuator), 32'(6'b000001));

    // round-robin over all channels, wrapping back to 0
    sensor = '0;
    apply_reset();
    rr_mode = 1'b1; sensor = '1;
    wait_for_act(6'b000001, "t4_first");
    for (int g = 0; g < 7; g++) begin
      for (int c = 0; c < HOLD; c++) begin
        e = '0;
        e[g % N] = 1'b1;
        chk("t4_rr_seq", 32'(actuator), 32'(e));
        tick();
      end
    end

    // grant outlives its own request, then goes idle
    sensor = '0;
    apply_reset();
    rr_mode = 1'b0; sensor = 6'b001000;
    wait_for_act(6'b001000, "t5_grant3");
    sensor = '0;
    measure_hold(6'b001000, held);
    chk("t5_hold", held, HOLD);
    chk("t5_idle_act", 32'(actuator), 0);
    chk("t5_idle_active", 32'(active), 0);

    // asynchronous reset in the middle of a grant
    apply_reset();
    sensor = 6'b000100;
    wait_for_act(6'b000100, "t6_grant2");
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_async_act", 32'(actuator), 0);
    chk("t6_async_disp", 32'(display), 0);
    chk("t6_async_active", 32'(active), 0);
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    while (!active && n < 30) begin tick(); n++; end
    chk("t6_regrant_latency", n, 7);

    // random traffic with varying toggle density and mode changes
    apply_reset();
    flip_div = 10;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      if (cyc % 200 == 0) flip_div = $urandom_range(3, 30);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, flip_div - 1) == 0) sensor[i] = ~sensor[i];
      if ($urandom_range(0, 49) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 499) == 0) apply_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
